// File: rtl/qr_pkg.sv
// qr_pkg: shared definitions for the QR sequencing block and the whitening
// datapath.
//   qr_state_t      - sequencer state encoding (also exposed on dbg_state)
//   QR_N_DEFAULT    - default matrix dimension
//   QR_ITER_DEFAULT - default number of sweeps per request
//   addr_w(n)       - address width for an n x n row-major matrix
//   row_w(n)        - width of a row index for an n x n matrix
package qr_pkg;

   localparam int QR_N_DEFAULT    = 4;
   localparam int QR_ITER_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ROT   = 3'd2,
      ST_APPLY = 3'd3,
      ST_DONE  = 3'd4
   } qr_state_t;

   function automatic int addr_w(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

   function automatic int row_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/qr_pair_gen.sv
// qr_pair_gen: walks the Givens rotation row pairs of one sweep.
// Order is q = 1..N-1 (outer), p = 0..q-1 (inner), so the sequence starts
// at (0,1) and ends at (N-2,N-1).
//   clk, rst - clock, asynchronous active-high reset
//   clear    - return to the first pair (0,1); wins over advance
//   advance  - step to the next pair
//   p, q     - current pair, p < q
//   last     - current pair is the final pair of the sweep
module qr_pair_gen #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          advance,
   output logic [PW-1:0] p,
   output logic [PW-1:0] q,
   output logic          last
);

   localparam logic [PW-1:0] P_LAST = PW'(N - 2);
   localparam logic [PW-1:0] Q_LAST = PW'(N - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p <= '0;
         q <= PW'(1);
      end else if (clear) begin
         p <= '0;
         q <= PW'(1);
      end else if (advance) begin
         // Inner index exhausted: move to the next column q, restart p at 0.
         if (p == q - PW'(1)) begin
            p <= '0;
            q <= q + PW'(1);
         end else begin
            p <= p + PW'(1);
         end
      end
   end

   assign last = (p == P_LAST) && (q == Q_LAST);

endmodule

// File: rtl/qr_sequencer.sv
// qr_sequencer: control-only responder for the GO_QR / QR_busy handshake.
// Runs ITER Givens sweeps over an N x N matrix: loads the matrix (read
// enables), then for every row pair requests a rotation and writes back the
// two rotated rows.
//
// Handshake: GO_QR is a level request held high for the whole run; dropping
// it in LOAD/ROT/APPLY aborts to IDLE. QR_busy covers the run, QR_done
// pulses for one cycle when it ends, and a still-high GO_QR does not start
// another run until it has been released. GO_rot is held high every ROT
// cycle; the cycle in which ROT_done is seen high ends the rotation.
//
// Ports:
//   CLK_QR, RST_QR  - clock, asynchronous active-high reset
//   GO_QR           - run request (level)
//   QR_busy/QR_done - run status / completion pulse
//   En_rd, En_wr    - matrix memory read / write enables
//   ADDR            - matrix memory address, row*N+col
//   PAIR_p, PAIR_q  - current rotation pair
//   GO_rot/ROT_done - rotation unit request / completion
//   ITER_cnt        - current sweep index
//   dbg_state       - current FSM state
//
// Outputs decode only registered state and counters, so none of them has a
// combinational path from an input, and reset clears them without a clock.
module qr_sequencer
   import qr_pkg::*;
#(
   parameter int N    = QR_N_DEFAULT,
   parameter int ITER = QR_ITER_DEFAULT,
   parameter int AW   = addr_w(N),
   parameter int PW   = row_w(N)
) (
   input  logic          CLK_QR,
   input  logic          RST_QR,
   input  logic          GO_QR,
   output logic          QR_busy,
   output logic          QR_done,
   output logic          En_rd,
   output logic          En_wr,
   output logic [AW-1:0] ADDR,
   output logic [PW-1:0] PAIR_p,
   output logic [PW-1:0] PAIR_q,
   output logic          GO_rot,
   input  logic          ROT_done,
   output logic [7:0]    ITER_cnt,
   output logic [2:0]    dbg_state
);

   localparam logic [AW-1:0] LOAD_LAST  = AW'(N * N - 1);
   localparam logic [AW-1:0] APPLY_LAST = AW'(2 * N - 1);
   localparam logic [AW-1:0] N_AW       = AW'(N);
   localparam logic [7:0]    ITER_LAST  = 8'(ITER - 1);

   qr_state_t     state, state_n;
   logic [AW-1:0] cnt;
   logic [7:0]    iter;
   logic          done_seen;

   logic cnt_clr, cnt_inc, iter_clr, iter_inc, pair_clr, pair_adv;
   logic [PW-1:0] p, q;
   logic          pair_last;
   logic [PW-1:0] row;
   logic [AW-1:0] col;

   qr_pair_gen #(.N(N), .PW(PW)) u_pair_gen (
      .clk     (CLK_QR),
      .rst     (RST_QR),
      .clear   (pair_clr),
      .advance (pair_adv),
      .p       (p),
      .q       (q),
      .last    (pair_last)
   );

   // State register and counters.
   always_ff @(posedge CLK_QR or posedge RST_QR) begin
      if (RST_QR) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         iter      <= '0;
         done_seen <= 1'b0;
      end else begin
         state <= state_n;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + AW'(1);
         if (iter_clr)      iter <= '0;
         else if (iter_inc) iter <= iter + 8'd1;
         // Marks that the first DONE cycle has passed.
         done_seen <= (state == ST_DONE);
      end
   end

   // Next-state and counter control.
   always_comb begin
      state_n  = state;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      iter_clr = 1'b0;
      iter_inc = 1'b0;
      pair_clr = 1'b0;
      pair_adv = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr  = 1'b1;
            iter_clr = 1'b1;
            pair_clr = 1'b1;
            if (GO_QR) state_n = ST_LOAD;
         end
         ST_LOAD, ST_ROT, ST_APPLY: begin
            if (!GO_QR) begin
               state_n  = ST_IDLE;
               cnt_clr  = 1'b1;
               iter_clr = 1'b1;
               pair_clr = 1'b1;
            end else if (state == ST_LOAD) begin
               if (cnt == LOAD_LAST) begin
                  state_n = ST_ROT;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (state == ST_ROT) begin
               if (ROT_done) begin
                  state_n = ST_APPLY;
                  cnt_clr = 1'b1;
               end
            end else if (cnt == APPLY_LAST) begin
               cnt_clr = 1'b1;
               if (!pair_last) begin
                  state_n  = ST_ROT;
                  pair_adv = 1'b1;
               end else if (iter < ITER_LAST) begin
                  state_n  = ST_LOAD;
                  iter_inc = 1'b1;
                  pair_clr = 1'b1;
               end else begin
                  state_n  = ST_DONE;
                  iter_clr = 1'b1;
                  pair_clr = 1'b1;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_DONE: begin
            if (!GO_QR) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // APPLY writes row p for the first N cycles, then row q.
   always_comb begin
      if (cnt < N_AW) begin
         row = p;
         col = cnt;
      end else begin
         row = q;
         col = cnt - N_AW;
      end
   end

   // Output decode from registered state.
   always_comb begin
      QR_busy   = 1'b0;
      QR_done   = 1'b0;
      En_rd     = 1'b0;
      En_wr     = 1'b0;
      ADDR      = '0;
      PAIR_p    = '0;
      PAIR_q    = '0;
      GO_rot    = 1'b0;
      ITER_cnt  = '0;
      dbg_state = state;
      case (state)
         ST_LOAD: begin
            QR_busy  = 1'b1;
            En_rd    = 1'b1;
            ADDR     = cnt;
            ITER_cnt = iter;
         end
         ST_ROT: begin
            QR_busy  = 1'b1;
            GO_rot   = 1'b1;
            PAIR_p   = p;
            PAIR_q   = q;
            ITER_cnt = iter;
         end
         ST_APPLY: begin
            QR_busy  = 1'b1;
            En_wr    = 1'b1;
            ADDR     = AW'(row) * N_AW + col;
            PAIR_p   = p;
            PAIR_q   = q;
            ITER_cnt = iter;
         end
         ST_DONE: begin
            QR_done = !done_seen;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_qr_sequencer.sv
// tb_qr_sequencer: randomized self-checking bench for qr_sequencer (N=4,
// ITER=2). For each run the reference model lays out the whole expected
// cycle trace (LOAD sweep, then per pair D rotation cycles and 2N write
// cycles, then DONE) from the sweep rules; the driver feeds ROT_done from
// that trace and compares every cycle.
module tb_qr_sequencer;
   import qr_pkg::*;

   localparam int N    = 4;
   localparam int ITER = 2;
   localparam int AW   = addr_w(N);
   localparam int PW   = row_w(N);
   localparam int VW   = 3 + 5 + AW + 2 * PW + 8;

   typedef struct packed {
      logic [2:0]    st;
      logic          busy;
      logic          done;
      logic          rd;
      logic          wr;
      logic          rot;
      logic [AW-1:0] addr;
      logic [PW-1:0] p;
      logic [PW-1:0] q;
      logic [7:0]    iter;
      logic          rin;   // ROT_done value to drive in this cycle
   } exp_t;
   localparam int EW = $bits(exp_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic go;
   logic rot_done;
   always #5 clk = ~clk;

   logic          qr_busy, qr_done, en_rd, en_wr, go_rot;
   logic [AW-1:0] addr;
   logic [PW-1:0] pair_p, pair_q;
   logic [7:0]    iter_cnt;
   logic [2:0]    dbg_state;

   qr_sequencer #(.N(N), .ITER(ITER)) dut (
      .CLK_QR    (clk),
      .RST_QR    (rst),
      .GO_QR     (go),
      .QR_busy   (qr_busy),
      .QR_done   (qr_done),
      .En_rd     (en_rd),
      .En_wr     (en_wr),
      .ADDR      (addr),
      .PAIR_p    (pair_p),
      .PAIR_q    (pair_q),
      .GO_rot    (go_rot),
      .ROT_done  (rot_done),
      .ITER_cnt  (iter_cnt),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [VW-1:0] obs();
      return {dbg_state, qr_busy, qr_done, en_rd, en_wr, go_rot, addr, pair_p, pair_q, iter_cnt};
   endfunction

   function automatic logic [VW-1:0] want_of(input exp_t e);
      return {e.st, e.busy, e.done, e.rd, e.wr, e.rot, e.addr, e.p, e.q, e.iter};
   endfunction

   function automatic logic [VW-1:0] quiet(input logic [2:0] st);
      exp_t e;
      e = '0;
      e.st = st;
      return want_of(e);
   endfunction

   // Reference trace for one complete run; each ROT holds for a random
   // number of cycles in [dmin,dmax].
   task automatic build_run(input int dmin, input int dmax);
      exp_t e;
      int   d;
      exp_q.delete();
      for (int s = 0; s < ITER; s++) begin
         for (int a = 0; a < N * N; a++) begin
            e = '0; e.st = ST_LOAD; e.busy = 1'b1; e.rd = 1'b1;
            e.addr = AW'(a); e.iter = 8'(s);
            exp_q.push_back(EW'(e));
         end
         for (int qq = 1; qq < N; qq++) begin
            for (int pp = 0; pp < qq; pp++) begin
               d = $urandom_range(dmin, dmax);
               for (int j = 0; j < d; j++) begin
                  e = '0; e.st = ST_ROT; e.busy = 1'b1; e.rot = 1'b1;
                  e.p = PW'(pp); e.q = PW'(qq); e.iter = 8'(s); e.rin = (j == d - 1);
                  exp_q.push_back(EW'(e));
               end
               for (int k = 0; k < 2 * N; k++) begin
                  e = '0; e.st = ST_APPLY; e.busy = 1'b1; e.wr = 1'b1;
                  e.addr = AW'(((k < N) ? pp : qq) * N + (k % N));
                  e.p = PW'(pp); e.q = PW'(qq); e.iter = 8'(s);
                  exp_q.push_back(EW'(e));
               end
            end
         end
      end
      e = '0; e.st = ST_DONE; e.done = 1'b1;
      exp_q.push_back(EW'(e));
   endtask

   // ---------------- driver ----------------
   // mode 0: full run, then GO held for 'hold' cycles and released
   // mode 1: GO dropped during ROT of pair (1,2) in the first sweep
   // mode 2: asynchronous reset mid-APPLY of pair (0,3) in the last sweep
   // Entered and left at 1 time unit after a rising edge.
   task automatic run(input int dmin, input int dmax, input int mode, input int hold,
                      input int busy_want);
      exp_t e;
      int   busy_cnt;
      bit   cut;
      busy_cnt = 0;
      cut = 1'b0;
      build_run(dmin, dmax);
      go = 1'b1;
      while (exp_q.size() > 0 && !cut) begin
         @(posedge clk); #1;
         e = exp_t'(exp_q.pop_front());
         check("cycle", obs(), want_of(e));
         busy_cnt += int'(qr_busy);
         if (mode == 1 && e.st == ST_ROT && e.p == PW'(1) && e.q == PW'(2) && e.iter == 8'd0) begin
            go = 1'b0;
            rot_done = 1'b0;
            @(posedge clk); #1;
            check("abort_idle", obs(), quiet(ST_IDLE));
            cut = 1'b1;
         end else if (mode == 2 && e.st == ST_APPLY && e.p == PW'(0) && e.q == PW'(3)
                      && e.iter == 8'(ITER - 1) && e.addr == AW'(3 * N + 1)) begin
            #2 rst = 1'b1;
            #1 check("async_rst", obs(), quiet(ST_IDLE));
            go = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               check("rst_idle", obs(), quiet(ST_IDLE));
            end
            cut = 1'b1;
         end else begin
            // Outside ROT the completion input is noise and must be ignored.
            if (e.rin)              rot_done = 1'b1;
            else if (e.st == ST_ROT) rot_done = 1'b0;
            else                     rot_done = 1'($urandom_range(0, 1));
         end
      end
      if (!cut) begin
         if (busy_want > 0) check("busy_len", VW'(busy_cnt), VW'(busy_want));
         repeat (hold) begin
            @(posedge clk); #1;
            rot_done = 1'($urandom_range(0, 1));
            check("held_go", obs(), quiet(ST_DONE));
         end
         go = 1'b0;
         @(posedge clk); #1;
         check("release", obs(), quiet(ST_IDLE));
      end
      exp_q.delete();
      rot_done = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      go = 1'b0;
      rot_done = 1'b0;
      #2 check("reset_async", obs(), quiet(ST_IDLE));
      repeat (2) @(posedge clk);
      #1 check("reset_state", obs(), quiet(ST_IDLE));
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_no_go", obs(), quiet(ST_IDLE));
      end

      // Every rotation answers on its 3rd cycle; GO held 50 cycles after done.
      run(3, 3, 0, 50, ITER * (N * N + (N * (N - 1) / 2) * (3 + 2 * N)));
      // ROT_done effectively tied high: one ROT cycle per pair.
      run(1, 1, 0, 2, ITER * (N * N + (N * (N - 1) / 2) * (1 + 2 * N)));
      // Abort, then a fresh run must start from the beginning.
      run(1, 4, 1, 0, 0);
      run(1, 4, 0, 1, 0);
      // Asynchronous reset mid-run, then a fresh run.
      run(1, 4, 2, 0, 0);
      for (int i = 0; i < 3; i++) run(1, 5, 0, $urandom_range(0, 5), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "time limit");
   end

endmodule
